reg_file_mp: RTL and testbench
==============================

REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register width in bits.
REQ-002 Parameter ADDR_W, default 5, SHALL set the register index width; DEPTH = 2**ADDR_W.
REQ-003 Parameter NUM_RD, default 2, SHALL set the number of independent read ports (range 1..4).
REQ-004 Parameter ZERO_REG, default 1, SHALL hardwire register 0 to zero when 1.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 rd_addr  in  NUM_RD*ADDR_W  packed read indices, port k at bits [k*ADDR_W +: ADDR_W].
REQ-008 rd_data  out  NUM_RD*DATA_W  packed read data, port k at bits [k*DATA_W +: DATA_W].
REQ-009 rd_pend  out  NUM_RD  per-port scoreboard pending bit for rd_addr[k].
REQ-010 wr0_en, wr1_en  in  1 each  write enables, ports 0 and 1.
REQ-011 wr0_addr, wr1_addr  in  ADDR_W each  write indices.
REQ-012 wr0_data, wr1_data  in  DATA_W each  write data.
REQ-013 sb_set_en  in  1; sb_set_addr  in  ADDR_W  mark a register pending (issued producer).
REQ-014 clear_req  in  1  request a full array clear.
REQ-015 clear_busy  out  1  high while the clear sweep runs.
REQ-016 clear_done  out  1  one-cycle pulse on the last sweep cycle.

Function
REQ-017 Reads SHALL be combinational; rd_data[k] = array[rd_addr[k]]; zero-latency.
REQ-018 With ZERO_REG=1, reads of index 0 SHALL return 0, and writes and sb_set to index 0 SHALL be ignored.
REQ-019 Enabled writes SHALL commit on the next rising edge; same address on both ports -> wr1 value commits.
REQ-020 Pending bits SHALL be DEPTH flops: sb_set_en sets bit; any committed write to that index clears it; set and clear of same index in one cycle -> bit ends set.
REQ-021 rd_pend[k] SHALL equal pending[rd_addr[k]], combinational.
REQ-022 FSM states SHALL be IDLE and CLEAR; IDLE->CLEAR on clear_req=1; CLEAR->IDLE after the cycle writing index DEPTH-1.
REQ-023 In CLEAR, a sweep counter SHALL zero one register per cycle, index 0 upward, DEPTH cycles total; clear_done asserts during the index DEPTH-1 cycle.
REQ-024 On entering CLEAR, all pending bits SHALL clear in one cycle.
REQ-025 While clear_busy=1: wr0/wr1/sb_set SHALL be dropped (no commit, no effect), rd_data SHALL read 0, rd_pend SHALL read 0, clear_req SHALL be ignored.
REQ-026 clear_req arriving with a simultaneous write in IDLE SHALL drop the write; sweep starts next cycle.
REQ-027 Sweep counter SHALL be ADDR_W+1 bits to avoid wrap-around at DEPTH-1.

Reset
REQ-028 rst=0 at a rising edge SHALL force state CLEAR, sweep counter 0, all pending bits 0.
REQ-029 Reset SHALL NOT zero the array directly; zeroing SHALL occur via the sweep (RAM-inferable array).
REQ-030 Output values under reset: clear_busy=1, clear_done=0, rd_data=0, rd_pend=0.
REQ-031 Reset asserted mid-sweep SHALL restart the sweep at index 0.

Configuration
REQ-032 Macro REG_FILE_MP_BYPASS_EN defined: a read of index i in IDLE with an enabled same-cycle write to i SHALL return the write data (wr1 over wr0) and rd_pend[k]=0 for that port; index 0 under ZERO_REG still returns 0.
REQ-033 Macro REG_FILE_MP_BYPASS_EN undefined: reads SHALL return the stored value; the new value is visible the cycle after commit.

Verification
REQ-034 Release rst after 2 cycles -> clear_busy=1 for exactly 32 cycles, clear_done pulses once, then all 32 registers read 0.
REQ-035 Same cycle wr0 (5, 0xAAAA_0000) and wr1 (5, 0x0000_5555) -> reg 5 reads 0x0000_5555 next cycle.
REQ-036 wr0 (0, 0xFFFF_FFFF), sb_set 0 -> rd_data 0, rd_pend 0.
REQ-037 sb_set 7; next cycle rd_pend=1; then sb_set 7 and wr0 (7, 0x12) together -> reg 7 = 0x12, rd_pend stays 1; then wr0 (7, 0x13) alone -> rd_pend 0.
REQ-038 Bypass build: write (3, 0xDEAD_BEEF) with rd_addr0=3 -> rd_data0=0xDEAD_BEEF same cycle; non-bypass build -> old value, then 0xDEAD_BEEF next cycle.
REQ-039 clear_req at cycle t with wr0 (9, 0x1) -> write dropped; rst=0 at sweep index 10 -> sweep restarts at 0 and runs a full 32 cycles.

Source files
------------

// File: rtl/reg_file_mp.sv
// Multi-port register file with producer scoreboard and a swept array clear.
// Optional macro REG_FILE_MP_BYPASS_EN forwards same-cycle write data to reads.
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_pend,
    input  logic                       wr0_en,
    input  logic [ADDR_W-1:0]          wr0_addr,
    input  logic [DATA_W-1:0]          wr0_data,
    input  logic                       wr1_en,
    input  logic [ADDR_W-1:0]          wr1_addr,
    input  logic [DATA_W-1:0]          wr1_data,
    input  logic                       sb_set_en,
    input  logic [ADDR_W-1:0]          sb_set_addr,
    input  logic                       clear_req,
    output logic                       clear_busy,
    output logic                       clear_done
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W:0]     r_cnt;
    logic [DEPTH-1:0]    r_pend;
    logic [DEPTH-1:0]    w_pend_nxt;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic w_idle;
    logic w_start;
    logic w_open;
    logic w_sweep;
    logic w_wr0;
    logic w_wr1;
    logic w_set;

    function automatic logic f_nz(input logic [ADDR_W-1:0] a);
        return (ZERO_REG == 0) || (a != '0);
    endfunction

    assign w_idle  = rst && (r_state == S_IDLE);
    assign w_start = w_idle && clear_req;
    assign w_open  = w_idle && !clear_req;
    assign w_sweep = rst && (r_state == S_CLEAR);
    assign w_wr0   = w_open && wr0_en && f_nz(wr0_addr);
    assign w_wr1   = w_open && wr1_en && f_nz(wr1_addr);
    assign w_set   = w_open && sb_set_en && f_nz(sb_set_addr);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_CLEAR && w_state_nxt == S_CLEAR)
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (clear_req) w_state_nxt = S_CLEAR;
            S_CLEAR: if (r_cnt == LAST) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    always_comb begin
        clear_busy = !rst || (r_state == S_CLEAR);
        clear_done = w_sweep && (r_cnt == LAST);
    end

    // Set wins over a same-cycle clearing write to the same index.
    always_comb begin
        w_pend_nxt = r_pend;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_wr0 && wr0_addr == ADDR_W'(i)) w_pend_nxt[i] = 1'b0;
            if (w_wr1 && wr1_addr == ADDR_W'(i)) w_pend_nxt[i] = 1'b0;
            if (w_set && sb_set_addr == ADDR_W'(i)) w_pend_nxt[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || w_start)
            r_pend <= '0;
        else
            r_pend <= w_pend_nxt;
    end

    // No reset on the array so it can map to RAM; the sweep zeroes it.
    always_ff @(posedge clk) begin
        if (w_sweep) begin
            r_mem[r_cnt[ADDR_W-1:0]] <= '0;
        end else begin
            if (w_wr0) r_mem[wr0_addr] <= wr0_data;
            if (w_wr1) r_mem[wr1_addr] <= wr1_data;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_rdv;
        logic              w_pv;

        assign w_ra = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            w_rdv = r_mem[w_ra];
            w_pv  = r_pend[w_ra];
`ifdef REG_FILE_MP_BYPASS_EN
            if (w_wr0 && wr0_addr == w_ra) begin
                w_rdv = wr0_data;
                w_pv  = 1'b0;
            end
            if (w_wr1 && wr1_addr == w_ra) begin
                w_rdv = wr1_data;
                w_pv  = 1'b0;
            end
`else
            w_rdv = w_rdv;
`endif
            if (clear_busy || !f_nz(w_ra)) begin
                w_rdv = '0;
                w_pv  = 1'b0;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = w_rdv;
        assign rd_pend[k]                  = w_pv;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp (default parameters).
// Expectations follow REG_FILE_MP_BYPASS_EN when the bench is built with it.
module tb_reg_file_mp;

    logic        clk;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_pend;
    logic        wr0_en;
    logic [4:0]  wr0_addr;
    logic [31:0] wr0_data;
    logic        wr1_en;
    logic [4:0]  wr1_addr;
    logic [31:0] wr1_data;
    logic        sb_set_en;
    logic [4:0]  sb_set_addr;
    logic        clear_req;
    logic        clear_busy;
    logic        clear_done;

    int total = 0;
    int bad   = 0;

    reg_file_mp dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_pend    (rd_pend),
        .wr0_en     (wr0_en),
        .wr0_addr   (wr0_addr),
        .wr0_data   (wr0_data),
        .wr1_en     (wr1_en),
        .wr1_addr   (wr1_addr),
        .wr1_data   (wr1_data),
        .sb_set_en  (sb_set_en),
        .sb_set_addr(sb_set_addr),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .clear_done (clear_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        wr0_en    = 1'b0;
        wr1_en    = 1'b0;
        sb_set_en = 1'b0;
        clear_req = 1'b0;
    endtask

    // Counts busy cycles from now until busy drops, bounded at 100.
    task automatic run_sweep(input bit poke, output int n, output int dn,
                             output int dpos);
        n = 0;
        dn = 0;
        dpos = -1;
        while (clear_busy && n < 100) begin
            if (poke && n >= 20 && n < 30) begin
                wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h77;
                wr1_en = 1'b1; wr1_addr = 5'd4; wr1_data = 32'h88;
                sb_set_en = 1'b1; sb_set_addr = 5'd6;
                clear_req = 1'b1;
            end else begin
                idle_inputs();
            end
            #1;
            n++;
            if (clear_done) begin
                dn++;
                dpos = n;
            end
            if (rd_data !== 64'd0 || rd_pend !== 2'b00) begin
                total++; bad++;
                $display("FAIL busy_read data=%h pend=%b need 0", rd_data, rd_pend);
            end
            step();
        end
        idle_inputs();
        #1;
    endtask

    task automatic test_reset;
        int n, dn, dpos;
        rst = 1'b0;
        rd_addr = {5'd2, 5'd1};
        step();
        step();
        total++;
        if (clear_busy !== 1'b1 || clear_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags busy=%b done=%b need 1/0", clear_busy, clear_done);
        end
        total++;
        if (rd_data !== 64'd0 || rd_pend !== 2'b00) begin
            bad++;
            $display("FAIL reset_read data=%h pend=%b need 0", rd_data, rd_pend);
        end
        rst = 1'b1;
        run_sweep(1'b0, n, dn, dpos);
        total++;
        if (n !== 32) begin
            bad++;
            $display("FAIL reset_busy_len got=%0d need=32", n);
        end
        total++;
        if (dn !== 1 || dpos !== 32) begin
            bad++;
            $display("FAIL reset_done pulses=%0d at=%0d need 1 at 32", dn, dpos);
        end
        for (int i = 0; i < 32; i++) begin
            rd_addr = {5'(31 - i), 5'(i)};
            #1;
            total++;
            if (rd_data !== 64'd0 || clear_busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_zero idx=%0d data=%h busy=%b need 0", i, rd_data, clear_busy);
            end
        end
    endtask

    task automatic test_dual_write;
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hAAAA_0000;
        wr1_en = 1'b1; wr1_addr = 5'd5; wr1_data = 32'h0000_5555;
        rd_addr = {5'd5, 5'd5};
        step();
        idle_inputs();
        #1;
        total++;
        if (rd_data !== {32'h0000_5555, 32'h0000_5555}) begin
            bad++;
            $display("FAIL dual_write got=%h need=%h", rd_data, {32'h0000_5555, 32'h0000_5555});
        end
        wr0_en = 1'b1; wr0_addr = 5'd10; wr0_data = 32'h0BAD_F00D;
        wr1_en = 1'b1; wr1_addr = 5'd11; wr1_data = 32'h1234_5678;
        step();
        idle_inputs();
        rd_addr = {5'd11, 5'd10};
        #1;
        total++;
        if (rd_data !== {32'h1234_5678, 32'h0BAD_F00D}) begin
            bad++;
            $display("FAIL split_write got=%h need=%h", rd_data, {32'h1234_5678, 32'h0BAD_F00D});
        end
    endtask

    task automatic test_zero_reg;
        wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFFFF_FFFF;
        sb_set_en = 1'b1; sb_set_addr = 5'd0;
        rd_addr = {5'd0, 5'd0};
        step();
        idle_inputs();
        #1;
        total++;
        if (rd_data !== 64'd0 || rd_pend !== 2'b00) begin
            bad++;
            $display("FAIL zero_reg data=%h pend=%b need 0", rd_data, rd_pend);
        end
    endtask

    task automatic test_scoreboard;
        sb_set_en = 1'b1; sb_set_addr = 5'd7;
        rd_addr = {5'd7, 5'd5};
        step();
        idle_inputs();
        #1;
        total++;
        if (rd_pend !== 2'b10) begin
            bad++;
            $display("FAIL sb_set pend=%b need=10", rd_pend);
        end
        sb_set_en = 1'b1; sb_set_addr = 5'd7;
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h12;
        step();
        idle_inputs();
        #1;
        total++;
        if (rd_data[63:32] !== 32'h12 || rd_pend !== 2'b10) begin
            bad++;
            $display("FAIL sb_set_wins data=%h pend=%b need 12/10", rd_data[63:32], rd_pend);
        end
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h13;
        step();
        idle_inputs();
        #1;
        total++;
        if (rd_data[63:32] !== 32'h13 || rd_pend !== 2'b00) begin
            bad++;
            $display("FAIL sb_clear data=%h pend=%b need 13/00", rd_data[63:32], rd_pend);
        end
    endtask

    task automatic test_bypass;
        logic [31:0] exp_now;
        logic        exp_pend;
`ifdef REG_FILE_MP_BYPASS_EN
        exp_now  = 32'hDEAD_BEEF;
        exp_pend = 1'b0;
`else
        exp_now  = 32'h0;
        exp_pend = 1'b1;
`endif
        sb_set_en = 1'b1; sb_set_addr = 5'd3;
        step();
        idle_inputs();
        rd_addr = {5'd0, 5'd3};
        wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'hDEAD_BEEF;
        #1;
        total++;
        if (rd_data[31:0] !== exp_now || rd_pend[0] !== exp_pend) begin
            bad++;
            $display("FAIL bypass_same data=%h pend=%b need %h/%b", rd_data[31:0], rd_pend[0], exp_now, exp_pend);
        end
        step();
        idle_inputs();
        #1;
        total++;
        if (rd_data[31:0] !== 32'hDEAD_BEEF || rd_pend[0] !== 1'b0) begin
            bad++;
            $display("FAIL bypass_next data=%h pend=%b need deadbeef/0", rd_data[31:0], rd_pend[0]);
        end
    endtask

    task automatic test_busy_drop;
        int n, dn, dpos;
        clear_req = 1'b1;
        rd_addr = {5'd4, 5'd3};
        #1;
        total++;
        if (clear_busy !== 1'b0 || rd_data[31:0] !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL req_cycle busy=%b data=%h need 0/deadbeef", clear_busy, rd_data[31:0]);
        end
        step();
        run_sweep(1'b1, n, dn, dpos);
        total++;
        if (n !== 32 || dn !== 1) begin
            bad++;
            $display("FAIL busy_sweep len=%0d done=%0d need 32/1", n, dn);
        end
        rd_addr = {5'd4, 5'd3};
        #1;
        total++;
        if (rd_data !== 64'd0) begin
            bad++;
            $display("FAIL busy_write_drop data=%h need 0", rd_data);
        end
        rd_addr = {5'd6, 5'd6};
        #1;
        total++;
        if (rd_pend !== 2'b00) begin
            bad++;
            $display("FAIL busy_sb_drop pend=%b need 00", rd_pend);
        end
    endtask

    task automatic test_clear_reset;
        int n, dn, dpos;
        wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h55;
        step();
        idle_inputs();
        clear_req = 1'b1;
        wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h1;
        step();
        idle_inputs();
        for (int i = 0; i < 10; i++) step();
        total++;
        if (clear_busy !== 1'b1 || dut.r_cnt !== 6'd10) begin
            bad++;
            $display("FAIL mid_sweep busy=%b cnt=%0d need 1/10", clear_busy, dut.r_cnt);
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        run_sweep(1'b0, n, dn, dpos);
        total++;
        if (n !== 32 || dn !== 1 || dpos !== 32) begin
            bad++;
            $display("FAIL restart_sweep len=%0d done=%0d at=%0d need 32/1/32", n, dn, dpos);
        end
        rd_addr = {5'd5, 5'd9};
        #1;
        total++;
        if (rd_data !== 64'd0) begin
            bad++;
            $display("FAIL clear_write_drop data=%h need 0", rd_data);
        end
    endtask

    initial begin
        rst = 1'b0;
        rd_addr = '0;
        wr0_addr = '0; wr0_data = '0;
        wr1_addr = '0; wr1_data = '0;
        sb_set_addr = '0;
        idle_inputs();
        test_reset();
        test_dual_write();
        test_zero_reg();
        test_scoreboard();
        test_bypass();
        test_busy_drop();
        test_clear_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
